// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin ALU/LSU/MDU onto one register-file port,
// plus a busy-bit scoreboard that stalls issue on outstanding long results.
module wb_arbiter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [4:0]            lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic                  mdu_valid,
    input  logic [4:0]            mdu_rd,
    input  logic [DATA_WIDTH-1:0] mdu_data,
    output logic                  mdu_ready,
    input  logic                  issue_valid,
    input  logic                  issue_long,
    input  logic [4:0]            issue_rs1,
    input  logic [4:0]            issue_rs2,
    input  logic [4:0]            issue_rd,
    output logic                  hazard_stall,
    output logic                  rf_reg_write,
    output logic [4:0]            rf_rd_addr,
    output logic [DATA_WIDTH-1:0] rf_rd_data,
    output logic                  rf_mem_to_reg,
    output logic [DATA_WIDTH-1:0] rf_mem_data
);

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MDU = 2'd2
    } src_e;

    src_e                  r_ptr;
    src_e                  w_ptr_next;
    logic [2:0]            w_gnt;
    logic [31:0]           r_busy;
    logic [31:0]           w_busy_next;
    logic                  w_set;
    logic [4:0]            w_wb_rd;
    logic [DATA_WIDTH-1:0] w_wb_data;

    // Search begins with the requester after the one granted last.
    always_comb begin
        w_gnt = 3'b000;
        case (r_ptr)
            SRC_ALU: begin
                if (lsu_valid)      w_gnt = 3'b010;
                else if (mdu_valid) w_gnt = 3'b100;
                else if (alu_valid) w_gnt = 3'b001;
            end
            SRC_LSU: begin
                if (mdu_valid)      w_gnt = 3'b100;
                else if (alu_valid) w_gnt = 3'b001;
                else if (lsu_valid) w_gnt = 3'b010;
            end
            default: begin
                if (alu_valid)      w_gnt = 3'b001;
                else if (lsu_valid) w_gnt = 3'b010;
                else if (mdu_valid) w_gnt = 3'b100;
            end
        endcase
    end

    assign alu_ready = w_gnt[0];
    assign lsu_ready = w_gnt[1];
    assign mdu_ready = w_gnt[2];

    always_comb begin
        w_ptr_next = r_ptr;
        if (w_gnt[0])      w_ptr_next = SRC_ALU;
        else if (w_gnt[1]) w_ptr_next = SRC_LSU;
        else if (w_gnt[2]) w_ptr_next = SRC_MDU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= SRC_MDU;
        else        r_ptr <= w_ptr_next;
    end

    always_comb begin
        w_wb_rd   = alu_rd;
        w_wb_data = alu_data;
        if (w_gnt[1]) begin
            w_wb_rd   = lsu_rd;
            w_wb_data = lsu_data;
        end else if (w_gnt[2]) begin
            w_wb_rd   = mdu_rd;
            w_wb_data = mdu_data;
        end
    end

    // Idle cycles return every writeback output to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_reg_write  <= 1'b0;
            rf_rd_addr    <= 5'd0;
            rf_rd_data    <= '0;
            rf_mem_to_reg <= 1'b0;
            rf_mem_data   <= '0;
        end else if (|w_gnt) begin
            rf_reg_write  <= (w_wb_rd != 5'd0);
            rf_rd_addr    <= w_wb_rd;
            rf_mem_to_reg <= w_gnt[1];
            rf_rd_data    <= w_gnt[1] ? '0 : w_wb_data;
            rf_mem_data   <= w_gnt[1] ? w_wb_data : '0;
        end else begin
            rf_reg_write  <= 1'b0;
            rf_rd_addr    <= 5'd0;
            rf_rd_data    <= '0;
            rf_mem_to_reg <= 1'b0;
            rf_mem_data   <= '0;
        end
    end

    assign hazard_stall = issue_valid &&
                          (r_busy[issue_rs1] || r_busy[issue_rs2] || r_busy[issue_rd]);
    assign w_set        = issue_valid && issue_long && !hazard_stall && (issue_rd != 5'd0);

    // Clear is applied before set so a same-cycle reissue keeps the register busy.
    always_comb begin
        w_busy_next = r_busy;
        if (w_gnt[1]) w_busy_next[lsu_rd] = 1'b0;
        if (w_gnt[2]) w_busy_next[mdu_rd] = 1'b0;
        if (w_set)    w_busy_next[issue_rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_next;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: arbitration order, writeback latency,
// scoreboard stalls and reset behaviour.
module tb_wb_arbiter;

    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic          alu_valid, lsu_valid, mdu_valid;
    logic [4:0]    alu_rd, lsu_rd, mdu_rd;
    logic [DW-1:0] alu_data, lsu_data, mdu_data;
    logic          alu_ready, lsu_ready, mdu_ready;
    logic          issue_valid, issue_long;
    logic [4:0]    issue_rs1, issue_rs2, issue_rd;
    logic          hazard_stall;
    logic          rf_reg_write;
    logic [4:0]    rf_rd_addr;
    logic [DW-1:0] rf_rd_data;
    logic          rf_mem_to_reg;
    logic [DW-1:0] rf_mem_data;

    int errorCount = 0;
    int checkCount = 0;

    wb_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .issue_valid(issue_valid), .issue_long(issue_long),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .hazard_stall(hazard_stall),
        .rf_reg_write(rf_reg_write), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_mem_to_reg(rf_mem_to_reg), .rf_mem_data(rf_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        alu_valid = 0; lsu_valid = 0; mdu_valid = 0;
        alu_rd = 0; lsu_rd = 0; mdu_rd = 0;
        alu_data = 0; lsu_data = 0; mdu_data = 0;
        issue_valid = 0; issue_long = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    endtask

    task automatic applyStimulus(input logic a, input logic l, input logic m);
        alu_valid = a; lsu_valid = l; mdu_valid = m;
        #1;
    endtask

    task automatic checkReadies(input string tag, input logic a, input logic l, input logic m);
        checkOutput({tag, ".alu_ready"}, DW'(alu_ready), DW'(a));
        checkOutput({tag, ".lsu_ready"}, DW'(lsu_ready), DW'(l));
        checkOutput({tag, ".mdu_ready"}, DW'(mdu_ready), DW'(m));
    endtask

    task automatic checkWb(input string tag, input logic we, input logic [4:0] rd,
                           input logic [DW-1:0] rdata, input logic m2r,
                           input logic [DW-1:0] mdata);
        checkOutput({tag, ".reg_write"}, DW'(rf_reg_write), DW'(we));
        checkOutput({tag, ".rd_addr"}, DW'(rf_rd_addr), DW'(rd));
        checkOutput({tag, ".rd_data"}, rf_rd_data, rdata);
        checkOutput({tag, ".mem_to_reg"}, DW'(rf_mem_to_reg), DW'(m2r));
        checkOutput({tag, ".mem_data"}, rf_mem_data, mdata);
    endtask

    initial begin
        clearInputs();
        rst_n = 0;
        stepCycle();
        stepCycle();
        checkWb("reset", 0, 0, 0, 0, 0);
        checkOutput("reset.stall", DW'(hazard_stall), 0);

        // Ready follows valid combinationally in reset, but nothing is written.
        alu_rd = 5'd7; alu_data = 64'h77;
        applyStimulus(1, 0, 0);
        checkReadies("rstReady", 1, 0, 0);
        stepCycle();
        checkWb("rstNoWrite", 0, 0, 0, 0, 0);
        clearInputs();
        rst_n = 1;
        #1;

        // Three-way round robin starting at ALU.
        alu_rd = 5'd5; alu_data = 64'h5555;
        lsu_rd = 5'd6; lsu_data = 64'h6666;
        mdu_rd = 5'd7; mdu_data = 64'h7777;
        applyStimulus(1, 1, 1);
        checkReadies("rr1", 1, 0, 0);
        stepCycle();
        checkWb("wbAlu", 1, 5, 64'h5555, 0, 0);
        checkReadies("rr2", 0, 1, 0);
        stepCycle();
        checkWb("wbLsu", 1, 6, 0, 1, 64'h6666);
        checkReadies("rr3", 0, 0, 1);
        stepCycle();
        checkWb("wbMdu", 1, 7, 64'h7777, 0, 0);
        clearInputs();
        applyStimulus(0, 0, 0);
        checkReadies("idle", 0, 0, 0);

        // Single LSU requester twice, then ALU beats LSU.
        lsu_rd = 5'd3; lsu_data = 64'hAB;
        applyStimulus(0, 1, 0);
        checkReadies("lsuOnly1", 0, 1, 0);
        stepCycle();
        checkWb("lsuWb1", 1, 3, 0, 1, 64'hAB);
        checkReadies("lsuOnly2", 0, 1, 0);
        stepCycle();
        checkWb("lsuWb2", 1, 3, 0, 1, 64'hAB);
        alu_rd = 5'd8; alu_data = 64'h11;
        applyStimulus(1, 1, 0);
        checkReadies("aluAfterLsu", 1, 0, 0);
        stepCycle();
        checkWb("aluWb", 1, 8, 64'h11, 0, 0);
        clearInputs();
        stepCycle();
        checkWb("noGrant", 0, 0, 0, 0, 0);

        // Write to x0 is consumed but never reaches the register file.
        alu_rd = 5'd0; alu_data = 64'hFF;
        applyStimulus(1, 0, 0);
        checkReadies("x0", 1, 0, 0);
        stepCycle();
        checkOutput("x0.reg_write", DW'(rf_reg_write), 0);
        clearInputs();

        // Long op to x9 stalls a dependent until the MDU result is accepted.
        issue_valid = 1; issue_long = 1; issue_rd = 5'd9;
        #1;
        checkOutput("issue9.stall", DW'(hazard_stall), 0);
        stepCycle();
        issue_long = 0; issue_rs1 = 5'd9; issue_rd = 5'd10;
        #1;
        checkOutput("dep9.stall1", DW'(hazard_stall), 1);
        stepCycle();
        checkOutput("dep9.stall2", DW'(hazard_stall), 1);
        mdu_rd = 5'd9; mdu_data = 64'h99;
        applyStimulus(0, 0, 1);
        checkReadies("mdu9", 0, 0, 1);
        checkOutput("dep9.noBypass", DW'(hazard_stall), 1);
        stepCycle();
        checkOutput("dep9.release", DW'(hazard_stall), 0);
        checkWb("mdu9Wb", 1, 9, 64'h99, 0, 0);
        clearInputs();

        // Set and clear of x4 in the same cycle: set wins.
        issue_valid = 1; issue_long = 1; issue_rd = 5'd4;
        lsu_rd = 5'd4; lsu_data = 64'h44;
        applyStimulus(0, 1, 0);
        checkReadies("lsu4", 0, 1, 0);
        checkOutput("issue4.stall", DW'(hazard_stall), 0);
        stepCycle();
        clearInputs();
        issue_valid = 1; issue_rs1 = 5'd4;
        #1;
        checkOutput("dep4.stall", DW'(hazard_stall), 1);
        checkWb("lsu4Wb", 1, 4, 0, 1, 64'h44);
        clearInputs();

        // Reset in the cycle after a grant drops the write and the busy bits.
        alu_rd = 5'd12; alu_data = 64'h12;
        applyStimulus(1, 0, 0);
        stepCycle();
        checkOutput("preRst.reg_write", DW'(rf_reg_write), 1);
        rst_n = 0;
        #1;
        checkOutput("midRst.reg_write", DW'(rf_reg_write), 0);
        checkOutput("midRst.rd_addr", DW'(rf_rd_addr), 0);
        stepCycle();
        clearInputs();
        rst_n = 1;
        stepCycle();
        checkOutput("postRst.reg_write", DW'(rf_reg_write), 0);
        issue_valid = 1; issue_rs1 = 5'd4;
        #1;
        checkOutput("postRst.stall", DW'(hazard_stall), 0);
        clearInputs();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
